// File: rtl/div_sequencer.sv
// div_sequencer: sequences the shared iterative divider; optional macro DIV_ZERO_FASTPATH_EN skips the divider for zero divisors
module div_sequencer #(
    parameter int DIV_LATENCY = 32,
    parameter int RD_W = 5,
    localparam int CNT_W = $clog2(DIV_LATENCY + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  logic [1:0]      req_op_i,
    input  logic [RD_W-1:0] req_rd_i,
    input  logic            req_zero_i,
    output logic            req_ready_o,
    input  logic            flush_i,
    output logic            unit_start_o,
    output logic [1:0]      unit_op_o,
    output logic            unit_kill_o,
    output logic            resp_valid_o,
    output logic [RD_W-1:0] resp_rd_o,
    input  logic            wb_ready_i,
    output logic            stall_exe_o,
    output logic            busy_o,
    output logic [31:0]     stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [RD_W-1:0]  rd_q;
    logic             accept, zero_fast;
    assign req_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign resp_rd_o   = rd_q;
    assign accept      = req_valid_i & req_ready_o & !flush_i;
`ifdef DIV_ZERO_FASTPATH_EN
    assign zero_fast = accept & req_zero_i;
`else
    logic unused_zero;
    assign unused_zero = req_zero_i;
    assign zero_fast   = 1'b0;
`endif
    // next state, divider control, response and stall decode
    always_comb begin
        state_d      = state_q;
        unit_start_o = 1'b0;
        unit_op_o    = op_q;
        unit_kill_o  = 1'b0;
        resp_valid_o = 1'b0;
        stall_exe_o  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                unit_start_o = !zero_fast;
                unit_op_o    = req_op_i;
                stall_exe_o  = 1'b1;
                state_d      = zero_fast ? DONE : BUSY;
            end
            BUSY: begin
                stall_exe_o = 1'b1;
                unit_kill_o = flush_i;
                state_d     = flush_i ? IDLE : (cnt_q == '0 ? DONE : BUSY);
            end
            DONE: begin
                resp_valid_o = 1'b1;
                stall_exe_o  = !wb_ready_i;
                unit_kill_o  = flush_i;
                state_d      = (flush_i | wb_ready_i) ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, latency counter, latched request and saturating stall counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            stall_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (stall_exe_o && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (accept) begin
                op_q  <= req_op_i;
                rd_q  <= req_rd_i;
                cnt_q <= CNT_W'(DIV_LATENCY - 1);
            end else if (state_q == BUSY) begin
                cnt_q <= (flush_i || cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer at latencies 32 and 1
module tb_div_sequencer;
    typedef struct {
        logic [4:0] rd;
        int         due;
    } exp_t;
    typedef struct {
        bit acc, bsy, dn, stall, kill, start;
    } exp_o_t;

    logic       clk_i = 1'b0;
    logic       rst_i, req_valid_i, req_zero_i, flush_i, wb_ready_i;
    logic [1:0] req_op_i;
    logic [4:0] req_rd_i;
    logic        req_ready[2], unit_start[2], unit_kill[2], resp_valid[2], stall[2], busy[2];
    logic [1:0]  unit_op[2];
    logic [4:0]  resp_rd[2];
    logic [31:0] stall_cnt[2];

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          in_flight[2] = '{0, 0};
    bit          fast[2] = '{0, 0};
    int          t_acc[2] = '{0, 0};
    logic [1:0]  m_op[2] = '{2'd0, 2'd0};
    logic [31:0] scnt[2] = '{32'd0, 32'd0};
    exp_t        sb[2][$];
    int          first_resp[2] = '{-1, -1};
    int          nresp[2] = '{0, 0};
    bit          prev_v[2] = '{0, 0};

    always #5 clk_i = ~clk_i;

    div_sequencer #(.DIV_LATENCY(32)) u_l32 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
        .req_rd_i(req_rd_i), .req_zero_i(req_zero_i), .req_ready_o(req_ready[0]),
        .flush_i(flush_i), .unit_start_o(unit_start[0]), .unit_op_o(unit_op[0]),
        .unit_kill_o(unit_kill[0]), .resp_valid_o(resp_valid[0]), .resp_rd_o(resp_rd[0]),
        .wb_ready_i(wb_ready_i), .stall_exe_o(stall[0]), .busy_o(busy[0]),
        .stall_cnt_o(stall_cnt[0])
    );

    div_sequencer #(.DIV_LATENCY(1)) u_l1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
        .req_rd_i(req_rd_i), .req_zero_i(req_zero_i), .req_ready_o(req_ready[1]),
        .flush_i(flush_i), .unit_start_o(unit_start[1]), .unit_op_o(unit_op[1]),
        .unit_kill_o(unit_kill[1]), .resp_valid_o(resp_valid[1]), .resp_rd_o(resp_rd[1]),
        .wb_ready_i(wb_ready_i), .stall_exe_o(stall[1]), .busy_o(busy[1]),
        .stall_cnt_o(stall_cnt[1])
    );

    function automatic int lat_of(input int i);
        return i == 0 ? 32 : 1;
    endfunction

    function automatic bit zero_req();
`ifdef DIV_ZERO_FASTPATH_EN
        return req_zero_i;
`else
        return 1'b0;
`endif
    endfunction

    // timeline view of one instance: an op accepted at t_acc is busy for lat cycles, then waits for writeback
    function automatic exp_o_t expect_o(input int i);
        exp_o_t r;
        int lat;
        int e;
        lat     = fast[i] ? 0 : lat_of(i);
        e       = cyc - t_acc[i];
        r.bsy   = in_flight[i] && e <= lat;
        r.dn    = in_flight[i] && e > lat;
        r.acc   = !in_flight[i] && req_valid_i && !flush_i;
        r.start = r.acc && !zero_req();
        r.kill  = in_flight[i] && flush_i;
        r.stall = r.acc || r.bsy || (r.dn && !wb_ready_i);
        return r;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[inst %0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // reference model: pushes expected responses on accept, drops them on flush or reset
    always @(posedge clk_i or posedge rst_i) begin
        for (int i = 0; i < 2; i++) begin
            exp_o_t r;
            bit zf;
            if (rst_i) begin
                in_flight[i] = 0;
                fast[i] = 0;
                m_op[i] = 2'd0;
                scnt[i] = 32'd0;
                sb[i].delete();
            end else begin
                r  = expect_o(i);
                zf = zero_req();
                if (r.stall && scnt[i] != 32'hFFFF_FFFF) scnt[i] = scnt[i] + 32'd1;
                if (r.acc) begin
                    in_flight[i] = 1;
                    t_acc[i] = cyc;
                    fast[i] = zf;
                    m_op[i] = req_op_i;
                    sb[i].push_back('{rd: req_rd_i, due: cyc + (zf ? 0 : lat_of(i)) + 1});
                end else if (r.kill) begin
                    in_flight[i] = 0;
                    sb[i].delete();
                end else if (r.dn && wb_ready_i) begin
                    in_flight[i] = 0;
                end
            end
        end
    end

    // monitor: compares DUT outputs mid-cycle and retires responses on the writeback handshake
    always @(negedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            exp_o_t r;
            bit ev;
            r  = expect_o(i);
            ev = sb[i].size() > 0 && cyc >= sb[i][0].due;
            chk("req_ready", i, 32'(req_ready[i]), 32'(!in_flight[i]));
            chk("busy", i, 32'(busy[i]), 32'(in_flight[i]));
            chk("unit_start", i, 32'(unit_start[i]), 32'(r.start));
            chk("unit_kill", i, 32'(unit_kill[i]), 32'(r.kill));
            chk("stall_exe", i, 32'(stall[i]), 32'(r.stall));
            chk("stall_cnt", i, stall_cnt[i], scnt[i]);
            chk("resp_valid", i, 32'(resp_valid[i]), 32'(ev));
            if (ev) chk("resp_rd", i, 32'(resp_rd[i]), 32'(sb[i][0].rd));
            if (r.start || r.bsy) chk("unit_op", i, 32'(unit_op[i]), 32'(r.start ? req_op_i : m_op[i]));
            if (resp_valid[i] && !prev_v[i]) begin
                first_resp[i] = cyc;
                nresp[i]++;
            end
            prev_v[i] = resp_valid[i];
            if (resp_valid[i] && wb_ready_i && !flush_i && sb[i].size() > 0) void'(sb[i].pop_front());
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [4:0] rd, input bit z, input bit fl, input bit wb);
        @(posedge clk_i);
        #1;
        req_valid_i = v;
        req_op_i    = op;
        req_rd_i    = rd;
        req_zero_i  = z;
        flush_i     = fl;
        wb_ready_i  = wb;
    endtask

    task automatic idle(input bit wb);
        drive(0, 2'd0, 5'd0, 0, 0, wb);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1;
        req_valid_i = 0; req_op_i = 0; req_rd_i = 0; req_zero_i = 0; flush_i = 0; wb_ready_i = 0;
        @(posedge clk_i);
        #1;
        rst_i = 0;
    endtask

    initial begin
        int t0;
        int n0;
        rst_i = 1;
        req_valid_i = 0; req_op_i = 0; req_rd_i = 0; req_zero_i = 0; flush_i = 0; wb_ready_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 0;

        drive(1, 2'd0, 5'd7, 0, 0, 1);
        t0 = cyc;
        n0 = nresp[0];
        repeat (40) idle(1);
        chk("single_resp_cycle", 0, first_resp[0], t0 + 33);
        chk("single_resp_count", 0, nresp[0] - n0, 1);
        chk("single_stall_cnt", 0, stall_cnt[0], 33);

        do_reset();
        drive(1, 2'd1, 5'd12, 0, 0, 0);
        t0 = cyc;
        repeat (37) idle(0);
        idle(1);
        idle(1);
        chk("bp_resp_cycle", 0, first_resp[0], t0 + 33);
        chk("bp_stall_cnt", 0, stall_cnt[0], 38);

        do_reset();
        drive(1, 2'd2, 5'd4, 0, 0, 1);
        t0 = cyc;
        n0 = nresp[0];
        repeat (9) idle(1);
        drive(0, 2'd0, 5'd0, 0, 1, 1);
        #1;
        chk("flush_kill", 0, 32'(unit_kill[0]), 1);
        drive(1, 2'd3, 5'd9, 0, 0, 1);
        #1;
        chk("flush_idle", 0, 32'(busy[0]), 0);
        chk("flush_restart", 0, 32'(unit_start[0]), 1);
        repeat (40) idle(1);
        chk("flush_resp_count", 0, nresp[0] - n0, 1);
        chk("flush_resp_cycle", 0, first_resp[0], t0 + 11 + 33);

        do_reset();
        drive(1, 2'd0, 5'd5, 0, 1, 1);
        #1;
        chk("idle_flush_start", 0, 32'(unit_start[0]), 0);
        chk("idle_flush_ready", 0, 32'(req_ready[0]), 1);
        idle(1);
        #1;
        chk("idle_flush_busy", 0, 32'(busy[0]), 0);

        do_reset();
        drive(1, 2'd1, 5'd6, 0, 0, 1);
        n0 = nresp[0];
        repeat (5) idle(1);
        @(posedge clk_i);
        #1;
        rst_i = 1;
        #1;
        chk("rst_stall_cnt", 0, stall_cnt[0], 0);
        chk("rst_busy", 0, 32'(busy[0]), 0);
        chk("rst_ready", 0, 32'(req_ready[0]), 1);
        @(posedge clk_i);
        #1;
        rst_i = 0;
        repeat (40) idle(1);
        chk("rst_no_resp", 0, nresp[0] - n0, 0);

        do_reset();
        drive(1, 2'd0, 5'd3, 1, 0, 1);
        t0 = cyc;
        repeat (40) idle(1);
`ifdef DIV_ZERO_FASTPATH_EN
        chk("zero_resp_cycle", 0, first_resp[0], t0 + 1);
`else
        chk("zero_resp_cycle", 0, first_resp[0], t0 + 33);
`endif

        repeat (3000)
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        repeat (40) idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
